// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU front-end: operator encodings and exponent bias.
package fpu_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  function automatic int calc_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/fpu_shift_sticky.sv
// Right shift of an extended mantissa with sticky collection into bit 0.
module fpu_shift_sticky #(
  parameter int XW = 27,
  parameter int SW = 8
) (
  input  logic [XW-1:0] din,
  input  logic [SW-1:0] shamt,
  output logic [XW-1:0] dout
);

  logic [31:0]   sh;
  logic [XW-1:0] ones;
  logic [XW-1:0] shifted;
  logic [XW-1:0] lost_mask;
  logic          sticky;

  always_comb begin
    sh        = 32'(shamt);
    ones      = '1;
    shifted   = din >> sh;
    lost_mask = ~(ones << sh);
    sticky    = |(din & lost_mask);
    // Shifting past the whole field leaves only the sticky of the original value
    if (sh >= 32'(XW)) begin
      dout = {{(XW-1){1'b0}}, |din};
    end else begin
      dout = {shifted[XW-1:1], shifted[0] | sticky};
    end
  end

endmodule

// File: rtl/fpu_align_pipe.sv
// Two-stage FPU operand alignment: S1 compare/swap or exponent sum, S2 shift with sticky.
module fpu_align_pipe
  import fpu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sign_1,
  input  logic               in_sign_2,
  input  logic [EXP_W-1:0]   in_exponent_1,
  input  logic [EXP_W-1:0]   in_exponent_2,
  input  logic [MAN_W-1:0]   in_mantissa_1,
  input  logic [MAN_W-1:0]   in_mantissa_2,
  input  logic [1:0]         in_operator,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sign_1,
  output logic               out_sign_2,
  output logic [EXP_W-1:0]   out_exponent,
  output logic [1:0]         out_operator,
  output logic [MAN_W+2:0]   out_mantissa_1,
  output logic [MAN_W+2:0]   out_mantissa_2,
  output logic               out_swapped,
  output logic               out_exp_ovf,
  output logic               out_exp_unf,
  output logic               out_invalid_op
);

  localparam int XW   = MAN_W + 3;
  localparam int BIAS = calc_bias(EXP_W);
  localparam logic signed [EXP_W+1:0] BIAS_S    = (EXP_W+2)'(BIAS);
  localparam logic signed [EXP_W+1:0] EXP_MAX_S = (EXP_W+2)'((1 << EXP_W) - 1);

  logic s1_en, s2_en;

  logic               s1_valid;
  logic               s1_sign_1, s1_sign_2, s1_swapped, s1_ovf, s1_unf, s1_invalid;
  logic [1:0]         s1_op;
  logic [EXP_W-1:0]   s1_exp, s1_shamt;
  logic [MAN_W-1:0]   s1_man_big, s1_man_small;

  logic               nx_sign_1, nx_sign_2, nx_swapped, nx_ovf, nx_unf, nx_invalid;
  logic [EXP_W-1:0]   nx_exp, nx_shamt;
  logic [MAN_W-1:0]   nx_man_big, nx_man_small;

  logic                      swap;
  logic signed [EXP_W+1:0]   exp_sum;
  logic [XW-1:0]             aligned_small;

  assign s2_en    = !out_valid || out_ready;
  assign s1_en    = !s1_valid || s2_en;
  assign in_ready = s1_en;

  assign swap = (in_exponent_2 > in_exponent_1) ||
                ((in_exponent_2 == in_exponent_1) && (in_mantissa_2 > in_mantissa_1));
  assign exp_sum = $signed({2'b00, in_exponent_1}) + $signed({2'b00, in_exponent_2}) - BIAS_S;

  always_comb begin
    nx_sign_1    = in_sign_1;
    nx_sign_2    = in_sign_2;
    nx_swapped   = 1'b0;
    nx_ovf       = 1'b0;
    nx_unf       = 1'b0;
    nx_invalid   = 1'b0;
    nx_exp       = '0;
    nx_shamt     = '0;
    nx_man_big   = in_mantissa_1;
    nx_man_small = in_mantissa_2;
    case (in_operator)
      OP_ADD, OP_SUB: begin
        nx_swapped = swap;
        if (swap) begin
          nx_sign_1    = in_sign_2;
          nx_sign_2    = in_sign_1;
          nx_exp       = in_exponent_2;
          nx_shamt     = in_exponent_2 - in_exponent_1;
          nx_man_big   = in_mantissa_2;
          nx_man_small = in_mantissa_1;
        end else begin
          nx_exp   = in_exponent_1;
          nx_shamt = in_exponent_1 - in_exponent_2;
        end
      end
      OP_MUL: begin
        if (exp_sum >= EXP_MAX_S) begin
          nx_exp = '1;
          nx_ovf = 1'b1;
        end else if (exp_sum[EXP_W+1] || (exp_sum == '0)) begin
          nx_unf = 1'b1;
        end else begin
          nx_exp = exp_sum[EXP_W-1:0];
        end
      end
      default: begin
        // Reserved operator: flag it and zero the data so it still flows harmlessly
        nx_invalid   = 1'b1;
        nx_man_big   = '0;
        nx_man_small = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid     <= 1'b0;
      s1_sign_1    <= 1'b0;
      s1_sign_2    <= 1'b0;
      s1_swapped   <= 1'b0;
      s1_ovf       <= 1'b0;
      s1_unf       <= 1'b0;
      s1_invalid   <= 1'b0;
      s1_op        <= '0;
      s1_exp       <= '0;
      s1_shamt     <= '0;
      s1_man_big   <= '0;
      s1_man_small <= '0;
    end else if (s1_en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign_1    <= nx_sign_1;
        s1_sign_2    <= nx_sign_2;
        s1_swapped   <= nx_swapped;
        s1_ovf       <= nx_ovf;
        s1_unf       <= nx_unf;
        s1_invalid   <= nx_invalid;
        s1_op        <= in_operator;
        s1_exp       <= nx_exp;
        s1_shamt     <= nx_shamt;
        s1_man_big   <= nx_man_big;
        s1_man_small <= nx_man_small;
      end
    end
  end

  fpu_shift_sticky #(
    .XW (XW),
    .SW (EXP_W)
  ) u_shift_sticky (
    .din   ({s1_man_small, 3'b000}),
    .shamt (s1_shamt),
    .dout  (aligned_small)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      out_sign_1     <= 1'b0;
      out_sign_2     <= 1'b0;
      out_exponent   <= '0;
      out_operator   <= '0;
      out_mantissa_1 <= '0;
      out_mantissa_2 <= '0;
      out_swapped    <= 1'b0;
      out_exp_ovf    <= 1'b0;
      out_exp_unf    <= 1'b0;
      out_invalid_op <= 1'b0;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_sign_1     <= s1_sign_1;
        out_sign_2     <= s1_sign_2;
        out_exponent   <= s1_exp;
        out_operator   <= s1_op;
        out_mantissa_1 <= {s1_man_big, 3'b000};
        out_mantissa_2 <= aligned_small;
        out_swapped    <= s1_swapped;
        out_exp_ovf    <= s1_ovf;
        out_exp_unf    <= s1_unf;
        out_invalid_op <= s1_invalid;
      end
    end
  end

endmodule

// File: tb/tb_fpu_align_pipe.sv
// Directed scoreboard bench for fpu_align_pipe (EXP_W=8, MAN_W=24).
module tb_fpu_align_pipe;

  typedef struct packed {
    logic        s1;
    logic        s2;
    logic [7:0]  exp;
    logic [26:0] m1;
    logic [26:0] m2;
    logic [1:0]  op;
    logic        sw;
    logic        ovf;
    logic        unf;
    logic        inv;
  } res_t;

  typedef struct packed {
    res_t r;
    int   acc;
    logic lat;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic        in_sign_1 = 1'b0, in_sign_2 = 1'b0;
  logic [7:0]  in_exponent_1 = '0, in_exponent_2 = '0;
  logic [23:0] in_mantissa_1 = '0, in_mantissa_2 = '0;
  logic [1:0]  in_operator = '0;
  logic        out_valid, out_ready = 1'b1;
  logic        out_sign_1, out_sign_2;
  logic [7:0]  out_exponent;
  logic [1:0]  out_operator;
  logic [26:0] out_mantissa_1, out_mantissa_2;
  logic        out_swapped, out_exp_ovf, out_exp_unf, out_invalid_op;

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  logic   lat_chk = 1'b1;
  entry_t sb_q[$];
  res_t   cur, held;
  logic   stalled_prev = 1'b0;

  fpu_align_pipe #(.EXP_W(8), .MAN_W(24)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_sign_1      (in_sign_1),
    .in_sign_2      (in_sign_2),
    .in_exponent_1  (in_exponent_1),
    .in_exponent_2  (in_exponent_2),
    .in_mantissa_1  (in_mantissa_1),
    .in_mantissa_2  (in_mantissa_2),
    .in_operator    (in_operator),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_sign_1     (out_sign_1),
    .out_sign_2     (out_sign_2),
    .out_exponent   (out_exponent),
    .out_operator   (out_operator),
    .out_mantissa_1 (out_mantissa_1),
    .out_mantissa_2 (out_mantissa_2),
    .out_swapped    (out_swapped),
    .out_exp_ovf    (out_exp_ovf),
    .out_exp_unf    (out_exp_unf),
    .out_invalid_op (out_invalid_op)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: bit-serial shift with sticky, integer exponent arithmetic
  function automatic res_t model(input logic [1:0] op, input logic sa, input logic sb,
                                 input logic [7:0] ea, input logic [7:0] eb,
                                 input logic [23:0] ma, input logic [23:0] mb);
    res_t r;
    logic [7:0] ebig, esml;
    logic [23:0] mbig, msml;
    logic [26:0] x;
    logic st;
    int d, s;
    r = '0;
    r.s1 = sa;
    r.s2 = sb;
    r.op = op;
    if (op == 2'b00 || op == 2'b01) begin
      r.sw = ({eb, mb} > {ea, ma});
      if (r.sw) begin
        ebig = eb; esml = ea; mbig = mb; msml = ma; r.s1 = sb; r.s2 = sa;
      end else begin
        ebig = ea; esml = eb; mbig = ma; msml = mb;
      end
      d = int'(ebig) - int'(esml);
      r.exp = ebig;
      r.m1 = {mbig, 3'b000};
      x = {msml, 3'b000};
      st = 1'b0;
      if (d >= 27) begin
        x = {26'd0, (msml != 24'd0)};
      end else begin
        for (int i = 0; i < d; i++) begin
          st = st | x[0];
          x = x >> 1;
        end
        x[0] = x[0] | st;
      end
      r.m2 = x;
    end else if (op == 2'b10) begin
      s = int'(ea) + int'(eb) - 127;
      r.m1 = {ma, 3'b000};
      r.m2 = {mb, 3'b000};
      if (s >= 255) begin
        r.exp = 8'hFF; r.ovf = 1'b1;
      end else if (s <= 0) begin
        r.exp = 8'h00; r.unf = 1'b1;
      end else begin
        r.exp = 8'(s);
      end
    end else begin
      r.inv = 1'b1;
    end
    return r;
  endfunction

  task automatic send(input logic [1:0] op, input logic sa, input logic sb,
                      input logic [7:0] ea, input logic [7:0] eb,
                      input logic [23:0] ma, input logic [23:0] mb);
    entry_t e;
    int n;
    in_operator = op; in_sign_1 = sa; in_sign_2 = sb;
    in_exponent_1 = ea; in_exponent_2 = eb;
    in_mantissa_1 = ma; in_mantissa_2 = mb;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept", 128'(in_ready), 128'(1'b1));
    e.r = model(op, sa, sb, ea, eb, ma, mb);
    e.acc = cyc;
    e.lat = lat_chk;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    chk("drain", 128'(sb_q.size()), 128'(0));
    #1;
  endtask

  always @(negedge clk) begin
    entry_t e;
    cur = {out_sign_1, out_sign_2, out_exponent, out_mantissa_1, out_mantissa_2,
           out_operator, out_swapped, out_exp_ovf, out_exp_unf, out_invalid_op};
    if (rst_n) begin
      if (stalled_prev && out_valid) chk("stall_hold", 128'(cur), 128'(held));
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_out", 128'(1'b1), 128'(1'b0));
        end else begin
          e = sb_q.pop_front();
          chk("result", 128'(cur), 128'(e.r));
          if (e.lat) chk("latency", 128'(cyc - e.acc), 128'(2));
        end
      end
      stalled_prev = out_valid && !out_ready;
      held = cur;
    end else begin
      stalled_prev = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
    chk("rst_mant_1", 128'(out_mantissa_1), 128'(0));
    chk("rst_exp", 128'(out_exponent), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'(1'b1));
    chk("rst_flags", 128'({out_swapped, out_exp_ovf, out_exp_unf, out_invalid_op}), 128'(0));
    @(posedge clk);
    #1;

    // add/sub alignment
    send(2'b00, 1'b0, 1'b0, 8'd130, 8'd128, 24'h800000, 24'hC00000);
    send(2'b01, 1'b0, 1'b1, 8'd100, 8'd120, 24'hA00000, 24'h900000);
    send(2'b00, 1'b1, 1'b0, 8'd200, 8'd100, 24'h800000, 24'h800001);
    send(2'b00, 1'b0, 1'b1, 8'd5,   8'd5,   24'h800000, 24'h900000);
    send(2'b00, 1'b0, 1'b0, 8'd10,  8'd7,   24'hFFFFFF, 24'h800003);
    send(2'b01, 1'b1, 1'b1, 8'd40,  8'd14,  24'h800000, 24'hC00000);
    send(2'b00, 1'b0, 1'b0, 8'd41,  8'd14,  24'h800000, 24'hC00000);
    send(2'b00, 1'b0, 1'b0, 8'd44,  8'd14,  24'h800000, 24'h000000);
    send(2'b00, 1'b1, 1'b0, 8'd77,  8'd77,  24'h812345, 24'h812345);
    // mul exponent boundaries
    send(2'b10, 1'b1, 1'b0, 8'd200, 8'd200, 24'h800000, 24'hFFFFFF);
    send(2'b10, 1'b0, 1'b1, 8'd10,  8'd20,  24'h900000, 24'hA00000);
    send(2'b10, 1'b0, 1'b0, 8'd190, 8'd191, 24'h800001, 24'h800002);
    send(2'b10, 1'b0, 1'b0, 8'd191, 8'd191, 24'h800001, 24'h800002);
    send(2'b10, 1'b0, 1'b0, 8'd60,  8'd67,  24'h800000, 24'h800000);
    send(2'b10, 1'b1, 1'b1, 8'd64,  8'd64,  24'hC00000, 24'h800000);
    send(2'b11, 1'b1, 1'b0, 8'd150, 8'd3,   24'hABCDEF, 24'h123456);
    drain();

    // backpressure: out_ready low for 5 cycles while 4 transactions are offered
    lat_chk = 1'b0;
    out_ready = 1'b0;
    fork
      begin
        send(2'b00, 1'b0, 1'b0, 8'd50, 8'd48, 24'h800000, 24'hF00001);
        send(2'b01, 1'b1, 1'b0, 8'd20, 8'd90, 24'h900000, 24'h800000);
        @(negedge clk);
        chk("bp_in_ready_low", 128'(in_ready), 128'(1'b0));
        send(2'b10, 1'b0, 1'b1, 8'd130, 8'd140, 24'h800000, 24'h800000);
        send(2'b00, 1'b1, 1'b1, 8'd9, 8'd9, 24'hC00000, 24'hC00000);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    lat_chk = 1'b1;

    // reset with two transactions in flight
    send(2'b00, 1'b0, 1'b0, 8'd30, 8'd29, 24'h800000, 24'h800000);
    send(2'b00, 1'b0, 1'b0, 8'd31, 8'd29, 24'h800000, 24'h800000);
    rst_n = 1'b0;
    #1;
    chk("reset_flush_valid", 128'(out_valid), 128'(1'b0));
    sb_q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(2'b01, 1'b1, 1'b0, 8'd66, 8'd70, 24'h812345, 24'hFEDCBA);
    drain();
    repeat (3) @(posedge clk);
    chk("idle_after_reset_test", 128'(out_valid), 128'(1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_align_pipe.md
FPU_ALIGN_PIPE -- requirements
Module: fpu_align_pipe

Interface
REQ-001 Parameter EXP_W, default 8, exponent width.
REQ-002 Parameter MAN_W, default 24, mantissa width including hidden bit.
REQ-003 Derived constants: BIAS = 2^(EXP_W-1)-1; XW = MAN_W+3, the extended mantissa width (guard, round, sticky).
REQ-004 clk  in  1  single clock; all state is updated on its rising edge.
REQ-005 rst_n  in  1  reset; asynchronous and active-low.
REQ-006 in_valid  in  1, and in_ready  out  1: input handshake; a transfer occurs when both are high on a clock edge.
REQ-007 in_sign_1, in_sign_2  in  1 each; in_exponent_1, in_exponent_2  in  EXP_W each; in_mantissa_1, in_mantissa_2  in  MAN_W each.
REQ-008 in_operator  in  2  operation select: 00 add, 01 sub, 10 mul, 11 reserved.
REQ-009 out_valid  out  1, and out_ready  in  1: output handshake; a transfer occurs when both are high on a clock edge.
REQ-010 out_sign_1, out_sign_2  out  1 each; out_exponent  out  EXP_W; out_operator  out  2.
REQ-011 out_mantissa_1, out_mantissa_2  out  XW each, aligned mantissas with GRS field in the three LSBs.
REQ-012 out_swapped, out_exp_ovf, out_exp_unf, out_invalid_op  out  1 each, status flags.

Function
REQ-013 The block SHALL be a two-stage pipeline: S1 performs compare/swap or exponent sum; S2 performs shift and sticky; latency is exactly 2 cycles when there is no backpressure.
REQ-014 Stage enables SHALL be: s2_en = !out_valid | out_ready; s1_en = !s1_valid | s2_en; in_ready = s1_en. Bubbles SHALL collapse.
REQ-015 While out_valid=1 and out_ready=0, all outputs SHALL hold stable; no transaction is dropped, duplicated or reordered.
REQ-016 Add/sub: swap operands, including signs, if e2>e1, or if e1==e2 and m2>m1; out_swapped is 1 when swapped.
REQ-017 Add/sub: out_exponent = the larger exponent; out_mantissa_1 = {big mantissa,3'b000}; out_mantissa_2 = {small mantissa,3'b000} >> (e_big - e_small).
REQ-018 Sticky (LSB of out_mantissa_2) SHALL be the OR of every bit shifted out, ORed with the shifted bit 0.
REQ-019 If the shift is >= XW, out_mantissa_2 SHALL be {XW-1 zeros, (small mantissa != 0)}.
REQ-020 Mul: no swap or shift; mantissas pass through as {m,3'b000}.
REQ-021 Mul: the exponent sum S = e1+e2-BIAS SHALL be computed in EXP_W+2 signed bits.
REQ-022 Mul with S >= 2^EXP_W-1: out_exponent SHALL be all-ones and out_exp_ovf=1.
REQ-023 Mul with S <= 0: out_exponent SHALL be 0 and out_exp_unf=1.
REQ-024 Operator 11: out_invalid_op=1 and all mantissa/exponent outputs SHALL be 0; the transaction still flows with normal latency.
REQ-025 out_sign_1, out_sign_2 and out_operator SHALL travel with their transaction; flags are valid only while out_valid=1.

Reset
REQ-026 On rst_n=0, asynchronously: s1_valid=0, out_valid=0, and all data and flag outputs = 0; in_ready = 1 once rst_n is released.
REQ-027 Transactions in flight at reset assertion SHALL be discarded; the first transaction accepted after reset completes normally.

Structure
REQ-028 Shared package fpu_pkg SHALL hold the operator encoding constants (OP_ADD, OP_SUB, OP_MUL, OP_RSVD) and the BIAS derivation.
REQ-029 The shift/sticky logic SHALL be a sub-module fpu_shift_sticky (parameter XW, combinational), instantiated in S2.

Verification (EXP_W=8, MAN_W=24)
REQ-030 add: e1=130, e2=128, m1=0x800000, m2=0xC00000 -> after 2 cycles: exp=130, mant_1=0x4000000, mant_2=0x1800000, swapped=0.
REQ-031 sub: e1=100, e2=120, sign_1=0, sign_2=1 -> exp=120, swapped=1, out_sign_1=1, out_sign_2=0.
REQ-032 add: e1=200, e2=100, m2=0x800001 -> mant_2=0x0000001, sticky=1; e1=e2=5, m2>m1 -> swapped=1.
REQ-033 mul: e1=e2=200 -> exp=255, ovf=1; e1=10, e2=20 -> exp=0, unf=1; op=11 -> invalid_op=1, data outputs 0.
REQ-034 Backpressure: 4 back-to-back transactions with out_ready=0 for 5 cycles -> in_ready falls after 2 transactions are accepted; all 4 emerge in order with outputs stable during stall.
REQ-035 Reset asserted with 2 transactions in flight -> out_valid=0 immediately; the next input appears 2 cycles after acceptance.
